// File: rtl/cpu_pkg.sv
// Shared CPU constants: program address width, PC-select encodings and stack opcodes.
package cpu_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    SEL_PC_INC = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_RET    = 2'b11
  } selectAdressT;

  localparam logic [4:0] OPC_CALL = 5'b11101;
  localparam logic [5:0] OPC_RET  = 6'b111100;

endpackage

// File: rtl/rstack_mem.sv
// Return-stack storage: DEPTH x ADDR_W register file, one write port, one async read port.
module rstack_mem #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clock,
  input  logic              wrEn,
  input  logic [PTR_W-1:0]  wrIdx,
  input  logic [ADDR_W-1:0] wrData,
  input  logic [PTR_W-1:0]  rdIdx,
  output logic [ADDR_W-1:0] rdData
);

  logic [ADDR_W-1:0] mem [DEPTH];

  // Contents are never reset; occupancy is tracked entirely by the top level.
  always_ff @(posedge clock) begin
    if (wrEn) mem[wrIdx] <= wrData;
  end

  assign rdData = mem[rdIdx];

endmodule

// File: rtl/return_stack.sv
// Call/return-address stack with registered pop output and sticky error flags.
// Define RSTACK_WRAP_EN to make a push while full overwrite the oldest entry.
module return_stack #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clock,
  input  logic              init_signal_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clear_err,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              ret_valid,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  logic [PTR_W-1:0]  spReg, spNext;
  logic [PTR_W:0]    countReg, countNext;
  logic [ADDR_W-1:0] retAddrReg, retAddrNext;
  logic              retValidReg;
  logic              ofReg, ufReg, ofSet, ufSet;
  logic              wrEn;
  logic [PTR_W-1:0]  wrIdx, topIdx;
  logic [ADDR_W-1:0] topData;

  assign topIdx = spReg - PTR_W'(1);
  assign empty  = (countReg == '0);
  assign full   = (countReg == (PTR_W+1)'(DEPTH));

  rstack_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) uMem (
    .clock  (clock),
    .wrEn   (wrEn),
    .wrIdx  (wrIdx),
    .wrData (push_addr),
    .rdIdx  (topIdx),
    .rdData (topData)
  );

  always_comb begin
    spNext      = spReg;
    countNext   = countReg;
    retAddrNext = retAddrReg;
    ofSet       = 1'b0;
    ufSet       = 1'b0;
    wrEn        = 1'b0;
    wrIdx       = spReg;
    if (pop && !empty) begin
      retAddrNext = topData;
      if (push) begin
        // Tail call: the popped slot is reused in place.
        wrEn  = 1'b1;
        wrIdx = topIdx;
      end else begin
        spNext    = topIdx;
        countNext = countReg - (PTR_W+1)'(1);
      end
    end else if (pop) begin
      retAddrNext = '0;
      ufSet       = 1'b1;
      if (push) begin
        wrEn      = 1'b1;
        spNext    = spReg + PTR_W'(1);
        countNext = countReg + (PTR_W+1)'(1);
      end
    end else if (push) begin
      if (!full) begin
        wrEn      = 1'b1;
        spNext    = spReg + PTR_W'(1);
        countNext = countReg + (PTR_W+1)'(1);
      end else begin
`ifdef RSTACK_WRAP_EN
        // sp already points at the oldest entry once the stack has wrapped.
        wrEn   = 1'b1;
        spNext = spReg + PTR_W'(1);
`else
        ofSet = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge init_signal_n) begin
    if (!init_signal_n) begin
      spReg       <= '0;
      countReg    <= '0;
      retAddrReg  <= '0;
      retValidReg <= 1'b0;
      ofReg       <= 1'b0;
      ufReg       <= 1'b0;
    end else begin
      spReg       <= spNext;
      countReg    <= countNext;
      retAddrReg  <= retAddrNext;
      retValidReg <= pop;
      ofReg       <= ofSet | (ofReg & ~clear_err);
      ufReg       <= ufSet | (ufReg & ~clear_err);
    end
  end

  assign ret_addr  = retAddrReg;
  assign ret_valid = retValidReg;
  assign count     = countReg;
  assign overflow  = ofReg;
  assign underflow = ufReg;

endmodule

// File: tb/tb_return_stack.sv
// Randomised scoreboard bench for return_stack; the reference model is a plain address queue.
module tb_return_stack;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;

  logic              clock = 1'b0;
  logic              init_signal_n = 1'b1;
  logic              push = 1'b0, pop = 1'b0, clear_err = 1'b0;
  logic [ADDR_W-1:0] push_addr = '0;
  logic [ADDR_W-1:0] ret_addr;
  logic              ret_valid, full, empty, overflow, underflow;
  logic [PTR_W:0]    count;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] mStack[$];
  logic [ADDR_W-1:0] expQ[$];
  bit mOf = 0, mUf = 0;

  always #5 clock = ~clock;

  return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock(clock), .init_signal_n(init_signal_n), .push(push), .pop(pop),
    .push_addr(push_addr), .clear_err(clear_err), .ret_addr(ret_addr),
    .ret_valid(ret_valid), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stack semantics: LIFO queue, pop on empty yields 0, full push drops or evicts the oldest.
  task automatic modelStep(input bit p, input bit q, input logic [ADDR_W-1:0] a, input bit c);
    bit setOf = 0, setUf = 0;
    if (q) begin
      if (mStack.size() > 0) expQ.push_back(mStack.pop_back());
      else begin
        expQ.push_back('0);
        setUf = 1;
      end
      if (p) mStack.push_back(a);
    end else if (p) begin
      if (mStack.size() < DEPTH) mStack.push_back(a);
      else begin
`ifdef RSTACK_WRAP_EN
        void'(mStack.pop_front());
        mStack.push_back(a);
`else
        setOf = 1;
`endif
      end
    end
    mOf = setOf | (mOf & !c);
    mUf = setUf | (mUf & !c);
  endtask

  task automatic step(input bit p, input bit q, input logic [ADDR_W-1:0] a, input bit c);
    push = p; pop = q; push_addr = a; clear_err = c;
    @(posedge clock);
    #1;
    modelStep(p, q, a, c);
    push = 0; pop = 0; clear_err = 0;
    $display("TX push=%0d pop=%0d addr=%h clr=%0d model_depth=%0d", p, q, a, c, mStack.size());
  endtask

  // Monitor: checks the registered outputs against the model once per cycle.
  initial begin
    forever begin
      @(negedge clock);
      check("ret_valid", {31'b0, ret_valid}, {31'b0, expQ.size() > 0});
      if (ret_valid && expQ.size() > 0) check("ret_addr", ret_addr, expQ.pop_front());
      else if (expQ.size() > 0) void'(expQ.pop_front());
      check("count", count, mStack.size());
      check("full", {31'b0, full}, {31'b0, mStack.size() == DEPTH});
      check("empty", {31'b0, empty}, {31'b0, mStack.size() == 0});
      check("overflow", {31'b0, overflow}, {31'b0, mOf});
      check("underflow", {31'b0, underflow}, {31'b0, mUf});
    end
  end

  initial begin
    #1 init_signal_n = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_ret_valid", {31'b0, ret_valid}, 0);
    check("rst_ret_addr", ret_addr, 0);
    check("rst_flags", {30'b0, overflow, underflow}, 0);
    #20 init_signal_n = 1'b1;

    // Basic LIFO order
    step(1, 0, 12'h010, 0);
    step(1, 0, 12'h020, 0);
    step(1, 0, 12'h030, 0);
    repeat (3) step(0, 1, '0, 0);
    step(0, 0, '0, 0);

    // Underflow and clear
    step(0, 1, '0, 0);
    step(0, 0, '0, 1);

    // Fill, push while full, then drain
    for (int i = 0; i < DEPTH; i++) step(1, 0, 12'h100 + 12'(i), 0);
    step(1, 0, 12'h1FF, 0);
    repeat (DEPTH) step(0, 1, '0, 0);

    // Overflow set wins over clear in the same cycle
    for (int i = 0; i < DEPTH; i++) step(1, 0, 12'h200 + 12'(i), 0);
    step(1, 0, 12'h2FF, 1);
    step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    while (mStack.size() > 0) step(0, 1, '0, 0);

    // Tail call replaces the top entry
    step(1, 0, 12'h055, 0);
    step(1, 1, 12'h0AA, 0);
    step(0, 1, '0, 0);
    step(1, 1, 12'h0CC, 0);
    step(0, 1, '0, 0);

    // Asynchronous reset between two pops
    step(0, 1, '0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 12'h300 + 12'(i), 0);
    step(0, 1, '0, 0);
    #1 init_signal_n = 1'b0;
    mStack.delete();
    expQ.delete();
    mOf = 0;
    mUf = 0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_ret_valid", {31'b0, ret_valid}, 0);
    check("async_rst_flags", {30'b0, overflow, underflow}, 0);
    #1 init_signal_n = 1'b1;
    step(0, 1, '0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           12'($urandom), 1'($urandom_range(0, 9) == 0));
    end

    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
